// File: rtl/trail_pkg.sv
// Shared definitions for the trail RAM write path.
//   FRAME_W / FRAME_H / NUM_PIXELS / ADDR_W : frame geometry and RAM addressing
//   COL_*                                   : colour codes stored per pixel
//   GNT_P1 / GNT_P2                         : encoding of the round-robin last_grant bit
//   arb_state_t                             : write arbiter FSM state
package trail_pkg;

  localparam int FRAME_W    = 640;
  localparam int FRAME_H    = 480;
  localparam int NUM_PIXELS = FRAME_W * FRAME_H;
  localparam int ADDR_W     = 19;

  localparam logic [7:0] COL_EMPTY = 8'h00;
  localparam logic [7:0] COL_P1    = 8'hFF;
  localparam logic [7:0] COL_P2    = 8'h80;

  localparam logic GNT_P1 = 1'b0;
  localparam logic GNT_P2 = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   CLOCK_50, reset : clock, synchronous active-high reset
//   req[1:0]        : bit 0 = player 1, bit 1 = player 2
//   enable          : when low no grant is issued
//   accept          : a granted write was taken this cycle; advances last_grant
//   grant[1:0]      : combinational one-hot (or zero) grant
module rr_arbiter2
  import trail_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);

  // Which requester won the most recent accepted write. Reset to P2 so
  // that P1 wins the first tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == GNT_P2) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      last_grant <= GNT_P2;
    end else if (accept) begin
      last_grant <= grant[1] ? GNT_P2 : GNT_P1;
    end
  end

endmodule

// File: rtl/trail_ram_write_arbiter.sv
// Owner of the trail RAM write port. Shares it between the two player trail
// writers (round-robin) and sweeps the whole frame with CLEAR_VAL after
// reset (AUTO_CLEAR) and on every clear_req.
//
// Handshake: a player write is accepted in any cycle where reqX && grantX.
// Grants are combinational from req, state and last_grant; a requester keeps
// addr/data stable while req is high and not yet granted, and may drop req
// at any time, in which case nothing is written.
//
// Ports:
//   CLOCK_50, reset          : system/RAM write clock, synchronous active-high reset
//   clear_req                : one-cycle pulse, start a frame clear
//   p1_req/addr/data/grant   : player 1 write request channel
//   p2_req/addr/data/grant   : player 2 write request channel
//   ram_wraddress/data/wren  : registered RAM write port (one cycle after accept)
//   clearing                 : high while the frame clear is in progress
//   clear_done               : one-cycle pulse after the last clear write is issued
//   oob_drop                 : one-cycle pulse when an accepted write is out of range
//   dbg_state                : current FSM state
module trail_ram_write_arbiter
  import trail_pkg::*;
#(
  parameter int              ADDR_W     = trail_pkg::ADDR_W,
  parameter int              DATA_W     = 8,
  parameter int              NUM_PIXELS = trail_pkg::NUM_PIXELS,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter bit              AUTO_CLEAR = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_grant,
  input  logic              p2_req,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_data,
  output logic              p2_grant,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              clearing,
  output logic              clear_done,
  output logic              oob_drop,
  output arb_state_t        dbg_state
);

  // One extra bit so NUM_PIXELS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              auto_pending;  // first cycle after reset, auto clear armed

  logic [1:0]        grant;
  logic              arb_enable;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // A clear request (explicit or automatic) beats any player request in the
  // same cycle, so the arbiter is disabled for that cycle too.
  assign arb_enable = (state == IDLE) && !reset && !clear_req && !auto_pending;

  rr_arbiter2 u_rr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      ({p2_req, p1_req}),
    .enable   (arb_enable),
    .accept   (accept),
    .grant    (grant)
  );

  assign p1_grant = grant[0];
  assign p2_grant = grant[1];
  assign accept   = (p1_req && grant[0]) || (p2_req && grant[1]);
  assign sel_addr = grant[1] ? p2_addr : p1_addr;
  assign sel_data = grant[1] ? p2_data : p1_data;

  assign clearing  = (state == CLEAR) && !reset;
  assign dbg_state = state;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      auto_pending  <= AUTO_CLEAR;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
      clear_done    <= 1'b0;
      oob_drop      <= 1'b0;
    end else begin
      ram_wren     <= 1'b0;
      clear_done   <= 1'b0;
      oob_drop     <= 1'b0;
      auto_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req || auto_pending) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (accept) begin
            if ({1'b0, sel_addr} < PIX_LIMIT) begin
              ram_wren      <= 1'b1;
              ram_wraddress <= sel_addr;
              ram_data      <= sel_data;
            end else begin
              oob_drop <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // clear_req is ignored here: the sweep is never restarted.
          ram_wren      <= 1'b1;
          ram_wraddress <= clr_cnt;
          ram_data      <= CLEAR_VAL;
          if (clr_cnt == LAST_ADDR) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trail_ram_write_arbiter.sv
module tb_trail_ram_write_arbiter;
  import trail_pkg::*;

  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int NPIX = 16;
  localparam int W    = AW + DW;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic          reset;
  logic          clear_req;
  logic          p1_req, p2_req;
  logic [AW-1:0] p1_addr, p2_addr;
  logic [DW-1:0] p1_data, p2_data;
  logic          p1_grant, p2_grant;
  logic [AW-1:0] ram_wraddress;
  logic [DW-1:0] ram_data;
  logic          ram_wren, clearing, clear_done, oob_drop;
  arb_state_t    dbg_state;

  trail_ram_write_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_PIXELS (NPIX),
    .CLEAR_VAL  (8'h00),
    .AUTO_CLEAR (1'b1)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .clear_req     (clear_req),
    .p1_req        (p1_req),
    .p1_addr       (p1_addr),
    .p1_data       (p1_data),
    .p1_grant      (p1_grant),
    .p2_req        (p2_req),
    .p2_addr       (p2_addr),
    .p2_data       (p2_data),
    .p2_grant      (p2_grant),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .clearing      (clearing),
    .clear_done    (clear_done),
    .oob_drop      (oob_drop),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];     // expected RAM writes {addr, data}, popped one cycle later
  bit            exp_wren, exp_done, exp_oob;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  int            clr_left;    // clear writes still to issue
  int            clr_idx;     // next clear address
  bit            start_pend;  // auto clear due on first post-reset cycle
  bit            last_p2;     // last accepted writer was player 2
  bit            eg1, eg2;    // model grants for the current cycle
  int            done_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset_state();
    exp_q.delete();
    exp_wren   = 1'b0;
    exp_done   = 1'b0;
    exp_oob    = 1'b0;
    held_addr  = '0;
    held_data  = '0;
    clr_left   = 0;
    clr_idx    = 0;
    start_pend = 1'b1;
    last_p2    = 1'b1;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the
  // model across the next posedge, returns at the following negedge.
  task automatic cycle();
    logic [W-1:0] e;
    bit busy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    busy = reset || clear_req || start_pend || (clr_left > 0);
    eg1  = !busy && p1_req && (!p2_req || last_p2);
    eg2  = !busy && p2_req && (!p1_req || !last_p2);
    check("p1_grant", 32'(p1_grant), 32'(eg1));
    check("p2_grant", 32'(p2_grant), 32'(eg2));
    check("clearing", 32'(clearing), 32'(!reset && clr_left > 0));
    if (!reset) check("state", 32'(dbg_state == CLEAR), 32'(clr_left > 0));
    check("ram_wren", 32'(ram_wren), 32'(exp_wren));
    check("clear_done", 32'(clear_done), 32'(exp_done));
    check("oob_drop", 32'(oob_drop), 32'(exp_oob));
    if (exp_wren) begin
      e = exp_q.pop_front();
      held_addr = e[W-1:DW];
      held_data = e[DW-1:0];
    end
    check("ram_wraddress", 32'(ram_wraddress), 32'(held_addr));
    check("ram_data", 32'(ram_data), 32'(held_data));
    if (clear_done) done_pulses++;

    exp_wren = 1'b0;
    exp_done = 1'b0;
    exp_oob  = 1'b0;
    if (reset) begin
      model_reset_state();
    end else if (clr_left > 0) begin
      exp_q.push_back({AW'(clr_idx), 8'h00});
      exp_wren = 1'b1;
      clr_idx++;
      clr_left--;
      if (clr_left == 0) exp_done = 1'b1;
    end else if (start_pend || clear_req) begin
      clr_left   = NPIX;
      clr_idx    = 0;
      start_pend = 1'b0;
    end else if (eg1 || eg2) begin
      a = eg1 ? p1_addr : p2_addr;
      d = eg1 ? p1_data : p2_data;
      if (int'(a) < NPIX) begin
        exp_q.push_back({a, d});
        exp_wren = 1'b1;
      end else begin
        exp_oob = 1'b1;
      end
      last_p2 = eg2;
    end
    @(negedge CLOCK_50);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    clear_req = 1'b0;
    p1_req    = 1'b0;
    p2_req    = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    clear_req = 1'b0;
    p1_req    = 1'b0;
    p2_req    = 1'b0;
    p1_addr   = '0;
    p2_addr   = '0;
    p1_data   = '0;
    p2_data   = '0;
    done_pulses = 0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    model_reset_state();
    run(2);

    // Auto clear after reset, no grants while clearing.
    reset = 1'b0;
    p1_req = 1'b1; p1_addr = 19'd9; p1_data = COL_P1;
    run(1);
    p1_req = 1'b0;
    run(19);
    check("auto_clear_done_count", 32'(done_pulses), 32'd1);

    // Single player-1 write.
    p1_req = 1'b1; p1_addr = 19'd5; p1_data = COL_P1;
    run(1);
    drive_idle();
    run(2);

    // Both requesting continuously: alternate P1/P2.
    p1_req = 1'b1; p1_addr = 19'd1; p1_data = COL_P1;
    p2_req = 1'b1; p2_addr = 19'd2; p2_data = COL_P2;
    run(6);
    drive_idle();
    run(1);

    // Out-of-range writes from both players.
    p2_req = 1'b1; p2_addr = 19'(NPIX); p2_data = COL_P2;
    run(1);
    drive_idle();
    run(1);
    p1_req = 1'b1; p1_addr = 19'h7FFFF; p1_data = COL_P1;
    run(1);
    drive_idle();
    run(1);

    // clear_req with p1_req; second clear_req mid-clear; p1 held until granted.
    clear_req = 1'b1;
    p1_req = 1'b1; p1_addr = 19'd3; p1_data = COL_P1;
    done_pulses = 0;
    run(1);
    clear_req = 1'b0;
    run(5);
    clear_req = 1'b1;
    run(1);
    clear_req = 1'b0;
    for (int i = 0; i < 40 && !eg1; i++) cycle();
    check("p1_granted_after_clear", 32'(eg1 ? 1 : 0), 32'd1);
    drive_idle();
    run(2);
    check("restart_clear_done_count", 32'(done_pulses), 32'd1);

    // Reset in the middle of a clear.
    clear_req = 1'b1;
    run(1);
    clear_req = 1'b0;
    run(7);
    done_pulses = 0;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(1);
    check("reset_abort_no_done", 32'(done_pulses), 32'd0);
    run(18);
    check("reset_reclear_done_count", 32'(done_pulses), 32'd1);

    // Randomized traffic with holding requesters, occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      clear_req = ($urandom_range(0, 59) == 0);
      if (!(p1_req && !eg1) || $urandom_range(0, 9) == 0) begin
        p1_req  = $urandom_range(0, 1) == 1;
        p1_addr = 19'($urandom_range(0, NPIX + 3));
        p1_data = 8'($urandom_range(0, 255));
      end
      if (!(p2_req && !eg2) || $urandom_range(0, 9) == 0) begin
        p2_req  = $urandom_range(0, 1) == 1;
        p2_addr = 19'($urandom_range(0, NPIX + 3));
        p2_data = 8'($urandom_range(0, 255));
      end
      cycle();
    end

    reset = 1'b0;
    drive_idle();
    run(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the stimulus is bounded, so this only fires on a simulator stall.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
